lsu_data_mem: RTL and testbench

//   Parametrised byte-addressable data memory with a load/store front end.

---
 rtl/lsu_data_mem.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_data_mem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_mem.sv
// Byte-addressable data memory behind a load/store front end. Accesses that cross a
// word boundary run as two beats (ACC0, ACC1). Load data is right-aligned and extended.
module lsu_data_mem #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [1:0]        o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // valid and the payload stay stable until that edge; ready never depends on valid.

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic                  cross_q, cross_d;
  logic                  err_q, err_d;
  logic [1:0]            size_q, size_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [MEM_AW-1:0]     idx_q, idx_d;
  logic [2*BYTES-1:0]    be_q, be_d;
  logic [2*DATA_W-1:0]   wsh_q, wsh_d;
  logic [DATA_W-1:0]     rd0_q, rd0_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [DATA_W-1:0]     mem [DEPTH];

  // Request decode, evaluated on the live request bus while IDLE.
  logic [OFF_W-1:0]      req_off;
  logic [IDX_W-1:0]      req_idx;
  logic [3:0]            req_nbytes;
  logic [4:0]            req_end;
  logic                  req_cross;
  logic                  req_err;
  logic [BYTES-1:0]      req_lanes;

  always_comb begin
    req_off    = i_req_addr[OFF_W-1:0];
    req_idx    = i_req_addr[ADDR_W-1:OFF_W];
    req_nbytes = 4'd1 << i_req_size;
    req_end    = 5'(req_off) + 5'(req_nbytes);
    req_cross  = (req_end > 5'(BYTES));
    req_err    = (int'(i_req_size) > OFF_W)
              || (req_idx >= IDX_W'(DEPTH))
              || (req_cross && (req_idx >= IDX_W'(DEPTH - 1)))
              || (req_cross && (MISALIGN_EN == 1'b0));
    for (int b = 0; b < BYTES; b++) begin
      req_lanes[b] = (b < int'(req_nbytes));
    end
  end

  // Single read port: beat 0 reads word idx, beat 1 reads idx+1.
  logic [MEM_AW-1:0]     rd_idx;
  logic [DATA_W-1:0]     rd_word;
  logic                  mem_we;
  logic [BYTES-1:0]      mem_be;
  logic [DATA_W-1:0]     mem_wd;

  assign rd_idx  = (state_q == ACC1) ? (idx_q + MEM_AW'(1)) : idx_q;
  assign rd_word = mem[rd_idx];

  // Load result: merge beats, shift down by the byte offset, extend from the top used byte.
  logic [2*DATA_W-1:0]   ld_both;
  logic [DATA_W-1:0]     ld_val;
  logic [DATA_W-1:0]     ld_res;
  logic [3:0]            ld_nb;
  logic                  ld_sign;

  always_comb begin
    ld_both = {((state_q == ACC1) ? rd_word : {DATA_W{1'b0}}),
               ((state_q == ACC0) ? rd_word : rd0_q)};
    ld_both = ld_both >> {off_q, 3'b000};
    ld_val  = ld_both[DATA_W-1:0];
    ld_nb   = 4'd1 << size_q;
    case (size_q)
      2'd0:    ld_sign = ld_val[7];
      2'd1:    ld_sign = ld_val[15];
      2'd2:    ld_sign = ld_val[31];
      default: ld_sign = ld_val[DATA_W-1];
    endcase
    for (int b = 0; b < BYTES; b++) begin
      ld_res[8*b +: 8] = (b < int'(ld_nb)) ? ld_val[8*b +: 8] : {8{ld_sign & ~uns_q}};
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    cross_d = cross_q;
    err_d   = err_q;
    size_d  = size_q;
    off_d   = off_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wsh_d   = wsh_q;
    rd0_d   = rd0_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    mem_be  = '0;
    mem_wd  = '0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          uns_d   = i_req_unsigned;
          cross_d = req_cross;
          size_d  = i_req_size;
          off_d   = req_off;
          idx_d   = req_idx[MEM_AW-1:0];
          be_d    = (2*BYTES)'(req_lanes) << req_off;
          wsh_d   = (2*DATA_W)'(i_req_wdata) << {req_off, 3'b000};
          rdata_d = '0;
          err_d   = req_err;
          state_d = req_err ? RESP : ACC0;
        end
      end
      ACC0: begin
        rd0_d   = rd_word;
        mem_we  = we_q;
        mem_be  = be_q[BYTES-1:0];
        mem_wd  = wsh_q[DATA_W-1:0];
        rdata_d = we_q ? '0 : ld_res;
        state_d = cross_q ? ACC1 : RESP;
      end
      ACC1: begin
        mem_we  = we_q;
        mem_be  = be_q[2*BYTES-1:BYTES];
        mem_wd  = wsh_q[2*DATA_W-1:DATA_W];
        rdata_d = we_q ? '0 : ld_res;
        state_d = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wsh_q   <= '0;
      rd0_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      cross_q <= cross_d;
      err_q   <= err_d;
      size_q  <= size_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wsh_q   <= wsh_d;
      rd0_q   <= rd0_d;
      rdata_q <= rdata_d;
    end
  end

  // Array has no reset so it maps onto RAM; mem_we drops as soon as reset forces IDLE.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_be[b]) mem[rd_idx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed bench for lsu_data_mem: aligned, sub-word, split, error, back-pressure
// and mid-split reset cases, with a second instance built with MISALIGN_EN = 0.
module tb_lsu_data_mem;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size, dbg_state;
  logic        rsp_valid, rsp_ready, rsp_err;

  logic        d2_req_valid, d2_req_ready, d2_rsp_valid, d2_rsp_ready, d2_rsp_err;
  logic [31:0] d2_req_addr, d2_rsp_rdata;
  logic [1:0]  d2_dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_data_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(512), .MISALIGN_EN(1'b1)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_dbg_state(dbg_state)
  );

  lsu_data_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(512), .MISALIGN_EN(1'b0)) dut_noms (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(d2_req_valid), .o_req_ready(d2_req_ready), .i_req_we(1'b0),
    .i_req_addr(d2_req_addr), .i_req_size(2'd2), .i_req_unsigned(1'b0),
    .i_req_wdata(32'h0), .o_rsp_valid(d2_rsp_valid), .i_rsp_ready(d2_rsp_ready),
    .o_rsp_rdata(d2_rsp_rdata), .o_rsp_err(d2_rsp_err), .o_dbg_state(d2_dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic st(input string tag, input logic [31:0] addr, input logic [1:0] size,
                    input logic [31:0] wdata, input logic exp_err, input int exp_lat);
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, addr, size, 1'b0, wdata, rd, er, lat);
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_rdata"}, 64'(rd), 64'h0);
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [1:0] size,
                    input logic uns, input logic [31:0] exp_data, input logic exp_err,
                    input int exp_lat);
    logic [31:0] rd; logic er; int lat;
    exp_q.push_back(exp_data);
    do_req(1'b0, addr, size, uns, 32'h0, rd, er, lat);
    check({tag, "_rdata"}, 64'(rd), 64'(exp_q.pop_front()));
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic ld_noms(input string tag, input logic [31:0] addr, input logic exp_err,
                         input int exp_lat);
    int lat;
    @(negedge clk);
    d2_req_valid = 1'b1; d2_req_addr = addr;
    @(posedge clk);
    #1 d2_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!d2_rsp_valid && lat < 20);
    check({tag, "_err"}, 64'(d2_rsp_err), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    d2_rsp_ready = 1'b1;
    @(posedge clk);
    #1 d2_rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    d2_req_valid = 1'b0; d2_req_addr = '0; d2_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rdata", 64'(rsp_rdata), 64'h0);
    check("rst_err", 64'(rsp_err), 64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);

    // Aligned word and sub-word accesses
    st("st_w10", 32'h10, 2'd2, 32'hDEADBEEF, 1'b0, 2);
    ld("ld_w10", 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 2);
    ld("ld_b13s", 32'h13, 2'd0, 1'b0, 32'hFFFFFFDE, 1'b0, 2);
    ld("ld_b13u", 32'h13, 2'd0, 1'b1, 32'h000000DE, 1'b0, 2);
    ld("ld_h12s", 32'h12, 2'd1, 1'b0, 32'hFFFFDEAD, 1'b0, 2);
    ld("ld_b10s", 32'h10, 2'd0, 1'b0, 32'hFFFFFFEF, 1'b0, 2);
    st("st_b11", 32'h11, 2'd0, 32'hAAAAAA55, 1'b0, 2);
    ld("ld_w10b", 32'h10, 2'd2, 1'b0, 32'hDEAD55EF, 1'b0, 2);

    // Split word store/load across 0x1C/0x20
    st("clr_1c", 32'h1C, 2'd2, 32'h0, 1'b0, 2);
    st("clr_20", 32'h20, 2'd2, 32'h0, 1'b0, 2);
    st("st_w1e", 32'h1E, 2'd2, 32'h11223344, 1'b0, 3);
    ld("ld_w1e", 32'h1E, 2'd2, 1'b0, 32'h11223344, 1'b0, 3);
    ld("ld_h1c", 32'h1C, 2'd1, 1'b1, 32'h00000000, 1'b0, 2);
    ld("ld_h1e", 32'h1E, 2'd1, 1'b1, 32'h00003344, 1'b0, 2);
    ld("ld_w1c", 32'h1C, 2'd2, 1'b0, 32'h33440000, 1'b0, 2);
    ld("ld_w20", 32'h20, 2'd2, 1'b0, 32'h00001122, 1'b0, 2);
    ld("ld_h1fs", 32'h1F, 2'd1, 1'b0, 32'h00002233, 1'b0, 3);

    // Errors and top-of-memory boundary
    st("st_w7fc", 32'h7FC, 2'd2, 32'hCAFEF00D, 1'b0, 2);
    ld("ld_800", 32'h800, 2'd2, 1'b0, 32'h0, 1'b1, 1);
    st("st_w7fe", 32'h7FE, 2'd2, 32'h12345678, 1'b1, 1);
    ld("ld_w7fc", 32'h7FC, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0, 2);
    ld("ld_h7fe", 32'h7FE, 2'd1, 1'b0, 32'hFFFFCAFE, 1'b0, 2);
    ld("ld_sz3", 32'h0, 2'd3, 1'b0, 32'h0, 1'b1, 1);
    ld_noms("noms_w1e", 32'h1E, 1'b1, 1);
    ld_noms("noms_w1c", 32'h1C, 1'b0, 2);

    // Response back-pressure with a concurrent request that must be ignored
    begin
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 20);
      check("bp_lat", 64'(n), 64'd2);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("bp_valid", 64'(rsp_valid), 64'h1);
        check("bp_rdata", 64'(rsp_rdata), 64'hDEAD55EF);
        check("bp_err", 64'(rsp_err), 64'h0);
        check("bp_req_ready", 64'(req_ready), 64'h0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_done_valid", 64'(rsp_valid), 64'h0);
    end
    ld("ld_after_bp", 32'h10, 2'd2, 1'b0, 32'hDEAD55EF, 1'b0, 2);

    // Reset during the second beat of a split store
    st("clr_2c", 32'h2C, 2'd2, 32'h0, 1'b0, 2);
    st("clr_30", 32'h30, 2'd2, 32'h0, 1'b0, 2);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2E; req_size = 2'd2; req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("rst_mid_state_acc1", 64'(dbg_state), 64'h2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(rsp_valid), 64'h0);
    check("rst_mid_rdata", 64'(rsp_rdata), 64'h0);
    check("rst_mid_err", 64'(rsp_err), 64'h0);
    check("rst_mid_state", 64'(dbg_state), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", 64'(req_ready), 64'h1);
    check("rst_rel_valid", 64'(rsp_valid), 64'h0);
    ld("ld_w2c", 32'h2C, 2'd2, 1'b0, 32'hC3D40000, 1'b0, 2);
    ld("ld_w30", 32'h30, 2'd2, 1'b0, 32'h00000000, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
